// File: rtl/dnn_argmax_fix.sv
// ----------------------------------------------------------------------------
// dnn_argmax_fix
//   Classification stage behind the fixed-point DNN core. On a start pulse
//   (tied to the core's done) the NUM_CLASSES signed scores are snapshotted.
//   They are then scanned one compare per cycle to find the winning class.
//   The winning index and score are presented on a valid/ready handshake.
//
//   Optional feature (compile-time macro DNN_ARGMAX_MARGIN_EN):
//     defined   - second-best score is tracked; margin = best - second.
//     undefined - no second-best logic; margin is tied to 0.
//   Latency is the same in both builds.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   clear         in   synchronous soft clear, active-high (beats start)
//   start         in   1-cycle pulse, accepted only in IDLE
//   scores        in   NUM_CLASSES x DATA_WIDTH signed scores
//   busy          out  high whenever the FSM is not IDLE
//   result_valid  out  result presented (HOLD), outputs stable while high
//   result_ready  in   consumer accepts the result
//   digit         out  index of the maximum score (lowest index on ties)
//   max_score     out  signed winning score
//   margin        out  unsigned best-minus-second (0 when feature is off)
//   start_dropped out  1-cycle pulse: a start arrived outside IDLE
//
// Timing: start sampled at edge E0; SCAN compares indices 1..NUM_CLASSES-1
// on edges E1..E(N-1); edge E(N) commits the result registers, so
// result_valid is high after edge E0+NUM_CLASSES.
// ----------------------------------------------------------------------------
module dnn_argmax_fix #(
  parameter int DATA_WIDTH  = 6,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  start,
  input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] scores,
  output logic                                  busy,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [IDX_WIDTH-1:0]                  digit,
  output logic [DATA_WIDTH-1:0]                 max_score,
  output logic [DATA_WIDTH:0]                   margin,
  output logic                                  start_dropped
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  // Counter must reach NUM_CLASSES, which is the commit step.
  localparam int              CNT_W = $clog2(NUM_CLASSES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLASSES);

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] snap [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best_q;
  logic signed [DATA_WIDTH-1:0] cur;
  logic [IDX_WIDTH-1:0]         best_idx_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         take_new;
  logic                         commit;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start)        state_d = SCAN;
        SCAN: if (commit)       state_d = HOLD;
        HOLD: if (result_ready) state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q != IDLE);
    result_valid = (state_q == HOLD);
  end

  // --------------------------------------------------------------------------
  // Scan datapath
  // --------------------------------------------------------------------------
  assign commit = (state_q == SCAN) && (cnt_q == LAST);

  // Element under comparison this cycle. Explicit compare-mux keeps the
  // index width independent of the counter width.
  always_comb begin
    cur = snap[0];
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if (cnt_q == CNT_W'(k)) cur = snap[k];
    end
  end

  // Strict compare: a tie never displaces the earlier (lower) index.
  assign take_new = (cur > best_q);

  // NOTE: the snapshot array is reset and cleared explicitly because its
  // zero state is architecturally visible; a plain storage memory would not
  // carry a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) snap[k] <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      cnt_q         <= '0;
      digit         <= '0;
      max_score     <= '0;
      start_dropped <= 1'b0;
    end else if (clear) begin
      for (int k = 0; k < NUM_CLASSES; k++) snap[k] <= '0;
      best_q        <= '0;
      best_idx_q    <= '0;
      cnt_q         <= '0;
      digit         <= '0;
      max_score     <= '0;
      start_dropped <= 1'b0;
    end else begin
      start_dropped <= start && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_CLASSES; k++) snap[k] <= scores[k];
            best_q     <= scores[0];
            best_idx_q <= '0;
            cnt_q      <= CNT_W'(1);
          end
        end
        SCAN: begin
          if (commit) begin
            digit     <= best_idx_q;
            max_score <= best_q;
          end else begin
            if (take_new) begin
              best_q     <= cur;
              best_idx_q <= IDX_WIDTH'(cnt_q);
            end
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional second-best / margin tracking
  // --------------------------------------------------------------------------
`ifdef DNN_ARGMAX_MARGIN_EN
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] second_q;
  logic [DATA_WIDTH:0]          diff;

  // best >= second always holds, so the widened difference is non-negative.
  assign diff = {best_q[DATA_WIDTH-1], best_q} - {second_q[DATA_WIDTH-1], second_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      second_q <= '0;
      margin   <= '0;
    end else if (clear) begin
      second_q <= '0;
      margin   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) second_q <= MOST_NEG;
        SCAN: begin
          if (commit)              margin   <= diff;
          else if (take_new)       second_q <= best_q;  // old best demoted
          else if (cur > second_q) second_q <= cur;     // includes ties with best
        end
        default: ;
      endcase
    end
  end
`else
  assign margin = '0;
`endif

endmodule
